// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 1-to-8 TDM receive demultiplexer with frame-sync alignment
module tdm_demux8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [7:0] a,
  output logic       out_valid,
  output logic [2:0] slot,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [6:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      shadow    <= 7'h00;
      a         <= 8'h00;
      out_valid <= 1'b0;
      slot      <= 3'd0;
      sync_err  <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      case (state)
        HUNT: begin
          // Unsynced bits are simply dropped while hunting for a frame start.
          if (din_valid && frame_sync) begin
            shadow[0] <= din;
            slot      <= 3'd1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (din_valid) begin
            if (frame_sync) begin
              // Early sync: the partial frame is abandoned and a new one starts at slot 0.
              sync_err  <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
              shadow[0] <= din;
              slot      <= 3'd1;
            end else if (slot == 3'd7) begin
              a         <= {din, shadow};
              out_valid <= 1'b1;
              slot      <= 3'd0;
              state     <= HUNT;
            end else begin
              shadow[slot] <= din;
              slot         <= slot + 3'd1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - randomized self-checking bench for tdm_demux8 against a frame-level model
module tb_tdm_demux8;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] a;
  logic       out_valid;
  logic [2:0] slot;
  logic       sync_err;
  logic [7:0] err_cnt;

  tdm_demux8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .a          (a),
    .out_valid  (out_valid),
    .slot       (slot),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ov_seen  = 0;
  int se_seen  = 0;

  // Reference: a frame is a list of received bits; a word exists once the list reaches 8.
  bit         q[$];
  bit         in_frame;
  logic [7:0] m_a;
  logic [7:0] m_cnt;
  logic       m_ov;
  logic       m_se;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_slot();
    return in_frame ? 3'(q.size()) : 3'd0;
  endfunction

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    m_a      = 8'h00;
    m_cnt    = 8'h00;
    m_ov     = 1'b0;
    m_se     = 1'b0;
  endtask

  task automatic model_update(input logic d, input logic v, input logic fs);
    m_ov = 1'b0;
    m_se = 1'b0;
    if (v) begin
      if (fs) begin
        if (in_frame) begin
          m_se = 1'b1;
          if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        end
        q.delete();
        q.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        q.push_back(d);
        if (q.size() == 8) begin
          for (int k = 0; k < 8; k++) m_a[k] = q[k];
          m_ov     = 1'b1;
          in_frame = 1'b0;
          q.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("a", {24'h0, a}, {24'h0, m_a});
    check("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
    check("slot", {29'h0, slot}, {29'h0, m_slot()});
    check("sync_err", {31'h0, sync_err}, {31'h0, m_se});
    check("err_cnt", {24'h0, err_cnt}, {24'h0, m_cnt});
  endtask

  task automatic step(input logic d, input logic v, input logic fs);
    din        = d;
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    model_update(d, v, fs);
    #1;
    if (out_valid) ov_seen++;
    if (sync_err) se_seen++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) step(w[k], 1'b1, k == 0);
  endtask

  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_a", {24'h0, a}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_slot", {29'h0, slot}, 32'h0);
    check("rst_sync_err", {31'h0, sync_err}, 32'h0);
    check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ov0;
    int se0;
    logic [7:0] gw;
    logic fs;
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Basic frame
    send_word(8'hAA);
    check("basic_a", {24'h0, a}, 32'hAA);
    check("basic_ov", {31'h0, out_valid}, 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("basic_ov_drop", {31'h0, out_valid}, 32'h0);

    // Gapped frame
    ov0 = ov_seen; se0 = se_seen; gw = 8'h5A;
    for (int k = 0; k < 3; k++) step(gw[k], 1'b1, k == 0);
    idle(3);
    for (int k = 3; k < 7; k++) step(gw[k], 1'b1, 1'b0);
    idle(5);
    step(gw[7], 1'b1, 1'b0);
    idle(2);
    check("gap_a", {24'h0, a}, 32'h5A);
    check("gap_ov_count", ov_seen - ov0, 1);
    check("gap_se_count", se_seen - se0, 0);

    // Hunt discard
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0);
    check("hunt_slot", {29'h0, slot}, 32'h0);
    send_word(8'h3C);
    check("hunt_a", {24'h0, a}, 32'h3C);

    // Early resync, from a clean reset so a goes 00 -> F0
    mid_reset();
    ov0 = ov_seen; se0 = se_seen;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0);
    send_word(8'hF0);
    check("resync_err_cnt", {24'h0, err_cnt}, 32'h1);
    check("resync_se_count", se_seen - se0, 1);
    check("resync_ov_count", ov_seen - ov0, 1);
    check("resync_a", {24'h0, a}, 32'hF0);

    // Back-to-back frames
    send_word(8'h81);
    check("b2b_a0", {24'h0, a}, 32'h81);
    send_word(8'h7E);
    check("b2b_a1", {24'h0, a}, 32'h7E);

    // Reset mid-frame then recover
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0);
    mid_reset();
    send_word(8'hC3);
    check("post_reset_a", {24'h0, a}, 32'hC3);

    // Saturation
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    check("sat_err_cnt", {24'h0, err_cnt}, 32'hFF);

    // Randomized traffic
    mid_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) mid_reset();
      if (m_slot() == 3'd0) fs = ($urandom_range(0, 7) != 0);
      else fs = ($urandom_range(0, 19) == 0);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, fs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
